// File: rtl/mul_div_iter_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit: operand width,
// funct3 op encodings and the control FSM state type.
package mul_div_iter_pkg;

    localparam int XLEN_DEF = 32;
    localparam int CNT_W    = 5;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // rs1 is treated as signed for every signed op; rs2 only for the fully signed ones
    function automatic logic rs1_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic rs2_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/mul_div_core.sv
// Unsigned radix-2 datapath: shift-add multiply or restoring divide on magnitudes,
// one iteration per step, with the iteration counter.
module mul_div_core
    import mul_div_iter_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            step_i,
    input  logic            is_div_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] hi_d_o,
    output logic [XLEN-1:0] lo_d_o,
    output logic            last_o
);

    // hi holds the upper product / partial remainder, lo the multiplier / quotient
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic [XLEN-1:0]  b_q, b_d;
    logic             div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [XLEN:0]    mul_sum;
    logic [XLEN:0]    div_shift;
    logic [XLEN+1:0]  div_diff;
    logic             div_ge;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + {1'b0, b_q};
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, b_q};
        div_ge    = ~div_diff[XLEN+1];

        hi_d  = hi_q;
        lo_d  = lo_q;
        b_d   = b_q;
        div_d = div_q;
        cnt_d = cnt_q;

        if (load_i) begin
            hi_d  = '0;
            lo_d  = a_i;
            b_d   = b_i;
            div_d = is_div_i;
            cnt_d = '0;
        end else if (step_i) begin
            cnt_d = cnt_q + 1'b1;
            if (div_q) begin
                hi_d = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], div_ge};
            end else if (lo_q[0]) begin
                hi_d = mul_sum[XLEN:1];
                lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
            end else begin
                hi_d = {1'b0, hi_q[XLEN-1:1]};
                lo_d = {hi_q[0], lo_q[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            b_q   <= b_d;
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

    // Next-state values let the top register the final result on the last step
    assign hi_d_o = hi_d;
    assign lo_d_o = lo_d;
    assign last_o = (cnt_q == CNT_W'(XLEN - 1));

endmodule

// File: rtl/mul_div_iter.sv
// Iterative RV32M multiply/divide: FSM, operand sign handling, divide special
// cases and registered register-file write port.
module mul_div_iter
    import mul_div_iter_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [4:0]      rd_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            wren_o,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] datard_o
);

    state_e          state_q, state_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [4:0]      rd_lat_q, rd_lat_d;
    logic            neg_q, neg_d;
    logic [4:0]      rd_out_q, rd_out_d;
    logic [XLEN-1:0] datard_q, datard_d;

    logic            in_s1, in_s2, in_is_div, in_is_rem;
    logic [XLEN-1:0] mag1, mag2;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] spec_res;

    logic            core_load, core_step, core_last;
    logic [XLEN-1:0] core_hi, core_lo;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0] quo_s, rem_s, final_res;

    mul_div_core #(.XLEN(XLEN)) u_core (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (core_load),
        .step_i   (core_step),
        .is_div_i (in_is_div),
        .a_i      (mag1),
        .b_i      (mag2),
        .hi_d_o   (core_hi),
        .lo_d_o   (core_lo),
        .last_o   (core_last)
    );

    // Operand decode at acceptance
    always_comb begin
        in_is_div = funct3_i[2];
        in_is_rem = funct3_i[2] & funct3_i[1];
        in_s1     = rs1_signed(funct3_i) & rs1_data_i[XLEN-1];
        in_s2     = rs2_signed(funct3_i) & rs2_data_i[XLEN-1];
        mag1      = in_s1 ? (~rs1_data_i + 1'b1) : rs1_data_i;
        mag2      = in_s2 ? (~rs2_data_i + 1'b1) : rs2_data_i;
        div_zero  = in_is_div && (rs2_data_i == '0);
        div_ovf   = (funct3_i == F3_DIV || funct3_i == F3_REM) &&
                    (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data_i == '1);
        if (div_zero)
            spec_res = in_is_rem ? rs1_data_i : '1;
        else
            spec_res = in_is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // Final result from the core's last-iteration values
    always_comb begin
        prod   = {core_hi, core_lo};
        prod_s = neg_q ? (~prod + 1'b1) : prod;
        quo_s  = neg_q ? (~core_lo + 1'b1) : core_lo;
        rem_s  = neg_q ? (~core_hi + 1'b1) : core_hi;
        case (funct3_q)
            F3_MUL:                      final_res = prod_s[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: final_res = prod_s[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:             final_res = quo_s;
            default:                     final_res = rem_s;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        funct3_d  = funct3_q;
        rd_lat_d  = rd_lat_q;
        neg_d     = neg_q;
        rd_out_d  = rd_out_q;
        datard_d  = datard_q;
        core_load = 1'b0;
        core_step = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    funct3_d = funct3_i;
                    rd_lat_d = rd_i;
                    neg_d    = in_is_rem ? in_s1 : (in_s1 ^ in_s2);
                    if (div_zero || div_ovf) begin
                        state_d  = ST_DONE;
                        datard_d = spec_res;
                        rd_out_d = rd_i;
                    end else begin
                        state_d   = ST_CALC;
                        core_load = 1'b1;
                    end
                end
            end
            ST_CALC: begin
                core_step = 1'b1;
                if (core_last) begin
                    state_d  = ST_DONE;
                    datard_d = final_res;
                    rd_out_d = rd_lat_q;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            funct3_q <= '0;
            rd_lat_q <= '0;
            neg_q    <= 1'b0;
            rd_out_q <= '0;
            datard_q <= '0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            rd_lat_q <= rd_lat_d;
            neg_q    <= neg_d;
            rd_out_q <= rd_out_d;
            datard_q <= datard_d;
        end
    end

    assign busy_o   = (state_q != ST_IDLE);
    assign done_o   = (state_q == ST_DONE);
    assign wren_o   = done_o && (rd_out_q != 5'd0);
    assign rd_o     = rd_out_q;
    assign datard_o = datard_q;

endmodule
